// File: rtl/intan_ctrl_mc.sv
// Multi-channel Intan front-end sequencer: check and config wait phases, then a read phase that
// streams a 2-byte channel id plus a kind-sized counting payload per channel into a byte FIFO.
module intan_ctrl_mc #(
  parameter int unsigned NCH   = 4,
  parameter int unsigned CKNUM = 100,
  parameter int unsigned CFNUM = 400
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [2*NCH-1:0]     i_dev_kind,
  output logic [2*NCH-1:0]     o_dev_type,
  input  logic [16*NCH-1:0]    i_chan_id,
  input  logic                 i_fs_check,
  input  logic                 i_fs_conf,
  input  logic                 i_fs_read,
  output logic                 o_fd_check,
  output logic                 o_fd_conf,
  output logic                 o_fd_read,
  output logic [7:0]           o_fifo_txd,
  output logic                 o_fifo_txen,
  input  logic                 i_fifo_full,
  output logic                 o_err,
  output logic [7:0]           o_so
);

  localparam logic [15:0] CkNum  = 16'(CKNUM);
  localparam logic [15:0] CfNum  = 16'(CFNUM);
  localparam logic [2:0]  LastCh = 3'(NCH - 1);

  typedef enum logic [7:0] {
    StIdle = 8'h11,
    StWfck = 8'h21,
    StBgck = 8'hA0,
    StGnck = 8'hA2,
    StLtck = 8'hA1,
    StFdck = 8'h12,
    StWfcf = 8'h41,
    StBgcf = 8'hB0,
    StGncf = 8'hB2,
    StLtcf = 8'hB1,
    StFdcf = 8'h22,
    StWfrd = 8'h81,
    StRdhh = 8'h83,
    StRdhl = 8'h85,
    StRdpl = 8'h87,
    StNxch = 8'h89,
    StFdrd = 8'h84
  } state_e;

  state_e            r_state, w_state_d;
  logic [15:0]       r_wnum, w_wnum_d;
  logic [2:0]        r_ch, w_ch_d;
  logic [7:0]        r_pcnt, w_pcnt_d;
  logic [2*NCH-1:0]  r_dev_type, w_dev_type_d;
  logic              r_txen, w_txen_d;
  logic [7:0]        r_txd, w_txd_d;
  logic              r_err, w_err_d;

  logic [1:0]        w_kind;
  logic [7:0]        w_len;
  logic [15:0]       w_id;
  logic              w_last;

  assign w_kind = r_dev_type[2*r_ch +: 2];
  assign w_id   = i_chan_id[16*r_ch +: 16];

  always_comb begin
    w_len = 8'd0;
    case (w_kind)
      2'b01:   w_len = 8'd32;
      2'b10:   w_len = 8'd64;
      2'b11:   w_len = 8'd128;
      default: w_len = 8'd0;
    endcase
  end

  assign w_last = (r_pcnt == (w_len - 8'd1));

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state    <= StIdle;
      r_wnum     <= '0;
      r_ch       <= '0;
      r_pcnt     <= '0;
      r_dev_type <= '0;
      r_txen     <= 1'b0;
      r_txd      <= '0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_wnum     <= w_wnum_d;
      r_ch       <= w_ch_d;
      r_pcnt     <= w_pcnt_d;
      r_dev_type <= w_dev_type_d;
      r_txen     <= w_txen_d;
      r_txd      <= w_txd_d;
      r_err      <= w_err_d;
    end
  end

  always_comb begin
    w_state_d    = r_state;
    w_wnum_d     = r_wnum;
    w_ch_d       = r_ch;
    w_pcnt_d     = r_pcnt;
    w_dev_type_d = r_dev_type;
    w_txen_d     = 1'b0;
    w_txd_d      = r_txd;
    w_err_d      = r_err;
    case (r_state)
      StIdle: begin
        w_dev_type_d = '0;
        w_state_d    = StWfck;
      end
      StWfck: if (i_fs_check) w_state_d = StBgck;
      StBgck: begin
        w_wnum_d = '0;
        if (!i_fs_check) begin
          w_err_d   = 1'b1;
          w_state_d = StWfck;
        end else begin
          w_state_d = StGnck;
        end
      end
      StGnck: begin
        if (!i_fs_check) begin
          w_err_d   = 1'b1;
          w_wnum_d  = '0;
          w_state_d = StWfck;
        end else begin
          w_wnum_d = r_wnum + 16'd1;
          if (r_wnum == CkNum) w_state_d = StLtck;
        end
      end
      StLtck: begin
        w_wnum_d     = '0;
        w_dev_type_d = i_dev_kind;
        w_state_d    = StFdck;
      end
      StFdck: if (!i_fs_check) w_state_d = StWfcf;
      StWfcf: if (i_fs_conf) w_state_d = StBgcf;
      StBgcf: begin
        w_wnum_d = '0;
        if (!i_fs_conf) begin
          w_err_d   = 1'b1;
          w_state_d = StWfcf;
        end else begin
          w_state_d = StGncf;
        end
      end
      StGncf: begin
        if (!i_fs_conf) begin
          w_err_d   = 1'b1;
          w_wnum_d  = '0;
          w_state_d = StWfcf;
        end else begin
          w_wnum_d = r_wnum + 16'd1;
          if (r_wnum == CfNum) w_state_d = StLtcf;
        end
      end
      StLtcf: begin
        w_wnum_d  = '0;
        w_state_d = StFdcf;
      end
      StFdcf: if (!i_fs_conf) w_state_d = StWfrd;
      StWfrd: begin
        if (i_fs_read) begin
          w_ch_d    = '0;
          w_pcnt_d  = '0;
          w_state_d = StRdhh;
        end
      end
      // Read states: an abort wins over emission; a full FIFO freezes everything.
      StRdhh: begin
        if (!i_fs_read) begin
          w_err_d   = 1'b1;
          w_state_d = StWfrd;
        end else if (w_len == 8'd0) begin
          w_state_d = StNxch;
        end else if (!i_fifo_full) begin
          w_txen_d  = 1'b1;
          w_txd_d   = w_id[15:8];
          w_state_d = StRdhl;
        end
      end
      StRdhl: begin
        if (!i_fs_read) begin
          w_err_d   = 1'b1;
          w_state_d = StWfrd;
        end else if (!i_fifo_full) begin
          w_txen_d  = 1'b1;
          w_txd_d   = w_id[7:0];
          w_pcnt_d  = '0;
          w_state_d = StRdpl;
        end
      end
      StRdpl: begin
        if (!i_fs_read) begin
          w_err_d   = 1'b1;
          w_state_d = StWfrd;
        end else if (!i_fifo_full) begin
          w_txen_d = 1'b1;
          w_txd_d  = r_pcnt;
          if (w_last) begin
            w_pcnt_d  = '0;
            w_state_d = StNxch;
          end else begin
            w_pcnt_d = r_pcnt + 8'd1;
          end
        end
      end
      StNxch: begin
        if (!i_fs_read) begin
          w_err_d   = 1'b1;
          w_state_d = StWfrd;
        end else if (r_ch == LastCh) begin
          w_state_d = StFdrd;
        end else begin
          w_ch_d    = r_ch + 3'd1;
          w_state_d = StRdhh;
        end
      end
      StFdrd: if (!i_fs_read) w_state_d = StWfrd;
      default: w_state_d = StIdle;
    endcase
  end

  assign o_dev_type  = r_dev_type;
  assign o_fifo_txen = r_txen;
  assign o_fifo_txd  = r_txd;
  assign o_err       = r_err;
  assign o_so        = r_state;
  assign o_fd_check  = (r_state == StFdck);
  assign o_fd_conf   = (r_state == StFdcf);
  assign o_fd_read   = (r_state == StFdrd);

endmodule

// File: doc/intan_ctrl_mc.md
INTAN_CTRL_MC -- requirements
Module: intan_ctrl_mc

Interface
Parameters (name, default, meaning):
REQ-001 NCH, 4, number of device channels (1..8).
REQ-002 CKNUM, 100, check-phase wait length in clk cycles (16-bit, at least 1).
REQ-003 CFNUM, 400, config-phase wait length in clk cycles (16-bit, at least 1).

Ports (name, direction, width, meaning):
REQ-004 clk, in, 1, single clock; reset is synchronous and active-low.
REQ-005 rst, in, 1, synchronous active-low reset.
REQ-006 dev_kind, in, 2*NCH, per-channel device kind; channel i uses bits [2i+1:2i].
REQ-007 dev_type, out, 2*NCH, latched device kind per channel.
REQ-008 chan_id, in, 16*NCH, per-channel 16-bit part identifier.
REQ-009 fs_check / fs_conf / fs_read, in, 1 each, phase start levels.
REQ-010 fd_check / fd_conf / fd_read, out, 1 each, phase done levels.
REQ-011 fifo_txd, out, 8, byte to the downstream FIFO.
REQ-012 fifo_txen, out, 1, write strobe: one byte per asserted cycle.
REQ-013 fifo_full, in, 1, downstream full flag.
REQ-014 err, out, 1, sticky protocol error flag.
REQ-015 so, out, 8, current state code for debug.

Function
REQ-016 State encodings: IDLE 8'h11; WFCK 8'h21; BGCK 8'hA0; GNCK 8'hA2; LTCK 8'hA1; FDCK 8'h12; WFCF 8'h41; BGCF 8'hB0; GNCF 8'hB2; LTCF 8'hB1; FDCF 8'h22; WFRD 8'h81; RDHH 8'h83; RDHL 8'h85; RDPL 8'h87; NXCH 8'h89; FDRD 8'h84.
REQ-017 Transitions:
- IDLE goes to WFCK.
- WFCK goes to BGCK on fs_check.
- BGCK goes to GNCK.
- GNCK goes to LTCK when wnum==CKNUM.
- LTCK goes to FDCK.
- FDCK goes to WFCF on ~fs_check.
- The config phase runs the same way with fs_conf and CFNUM.
- FDCF goes to WFRD on ~fs_conf.
REQ-018 wnum is 16-bit:
- cleared in BG*/LT* states;
- incremented in GN* states;
- held otherwise.
REQ-019 In LTCK, dev_type is loaded from dev_kind.
REQ-020 In IDLE, dev_type is cleared.
REQ-021 Per-channel payload length from dev_type: 00→0, 01→32, 10→64, 11→128 bytes.
REQ-022 WFRD goes to RDHH on fs_read, with channel index ch=0.
REQ-023 If channel ch has length 0, RDHH goes directly to NXCH and emits no bytes.
REQ-024 Read-phase byte emission for each enabled channel:
- RDHH emits chan_id[16ch+15:16ch+8];
- RDHL then emits the low byte;
- RDPL then emits payload bytes 0x00,0x01,… (8-bit counter) until length bytes have been sent.
REQ-025 In RD* states, a byte is emitted and the state/counter advance only in cycles with ~fifo_full; otherwise everything holds and fifo_txen=0.
REQ-026 NXCH: if ch==NCH-1, go to FDRD; otherwise increment ch and go to RDHH. Channels are always visited in ascending order.
REQ-027 FDRD goes to WFRD on ~fs_read.
REQ-028 fd_check=(state==FDCK), fd_conf=(state==FDCF), fd_read=(state==FDRD). These are combinational decodes and so=state.
REQ-029 fifo_txen and fifo_txd are registered: the byte appears the cycle after the emitting state accepts it.
REQ-030 Abort, check/config phase: fs_check low in BGCK/GNCK, or fs_conf low in BGCF/GNCF, sets err and returns to the phase's WF* state with wnum cleared.
REQ-031 Abort, read phase: fs_read low in any RD*/NXCH state sets err and returns to WFRD. A partial packet is left unterminated and no further bytes are emitted.
REQ-032 err clears only on reset.
REQ-033 Unknown state codes go to IDLE.
REQ-034 Once started, a phase ignores start inputs other than its own.

Reset
REQ-035 On a clk edge with rst=0, the block enters these values: state=IDLE, wnum=0, ch=0, payload counter=0, dev_type=0, fifo_txen=0, fifo_txd=0, err=0.
REQ-036 All fd_* outputs are 0 after reset.
REQ-037 Reset has priority over all other activity, including mid-packet.

Verification
REQ-038 Check phase: fs_check=1 held with dev_kind=8'b11_10_01_00 → fd_check rises 103 cycles after leaving WFCK, and dev_type=8'hE4.
REQ-039 Read phase: NCH=4, dev_type=8'hE4, chan_id ch1=16'h1234, fs_read=1, fifo_full=0 → ch0 emits nothing; ch1 emits 12,34,00..1F; ch2 emits 66 bytes; ch3 emits 130 bytes. The total is 230 txen pulses, then fd_read=1.
REQ-040 Backpressure: fifo_full=1 for 5 cycles mid-payload → txen=0 during those cycles and the byte sequence has no gap or duplicate.
REQ-041 Abort: fs_conf dropped at wnum=200 → err=1, state=WFCF; a later full config completes normally with err still 1.
REQ-042 Reset mid-packet: rst=0 for one cycle during RDPL → next cycle state=8'h11, txen=0, err=0.
REQ-043 Handshake: fs_read held high after FDRD → block stays in FDRD; fs_read=0 → WFRD; fs_read=1 again → a new read starts with payload from 0x00.
